// File: rtl/jesd_tx_link_ctrl_if.sv
// Link-control bundle between the JESD204B TX sequencer and its environment:
// frame tick, SYNC~ event levels and K going in, mode/LMFC/debug status coming out.
interface jesd_tx_link_ctrl_if #(
  parameter int ERR_CNT_W = 8
);
    logic                 frame_clk;
    logic [4:0]           i_K;
    logic                 i_sync_request_tx;
    logic                 i_err_reporting;
    logic                 i_sync_de_assertion;
    logic [1:0]           o_state;
    logic                 o_send_cgs;
    logic                 o_send_ilas;
    logic                 o_data_en;
    logic [2:0]           o_ilas_mf_idx;
    logic [4:0]           o_frame_in_mf;
    logic                 o_lmfc_boundary;
    logic [ERR_CNT_W-1:0] o_err_cnt;

    modport master (
        output frame_clk, i_K, i_sync_request_tx, i_err_reporting, i_sync_de_assertion,
        input  o_state, o_send_cgs, o_send_ilas, o_data_en, o_ilas_mf_idx,
               o_frame_in_mf, o_lmfc_boundary, o_err_cnt
    );

    modport slave (
        input  frame_clk, i_K, i_sync_request_tx, i_err_reporting, i_sync_de_assertion,
        output o_state, o_send_cgs, o_send_ilas, o_data_en, o_ilas_mf_idx,
               o_frame_in_mf, o_lmfc_boundary, o_err_cnt
    );
endinterface

// File: rtl/jesd_tx_link_ctrl.sv
// JESD204B TX link-layer sequencer: CGS -> WAIT_LMFC -> ILAS -> DATA, with a
// free-running LMFC frame counter so ILAS always starts on a multiframe boundary.
module jesd_tx_link_ctrl #(
    parameter int ILAS_MF   = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    jesd_tx_link_ctrl_if.slave lnk
);

    typedef enum logic [1:0] {
        ST_CGS       = 2'd0,
        ST_WAIT_LMFC = 2'd1,
        ST_ILAS      = 2'd2,
        ST_DATA      = 2'd3
    } state_t;

    localparam logic [2:0] ILAS_LAST = 3'(ILAS_MF - 1);

    state_t               state, state_nxt;
    logic [2:0]           ilas_idx, ilas_idx_nxt;
    logic [4:0]           k_q;
    logic [4:0]           frame_cnt;
    logic                 boundary;
    logic                 err_prev;
    logic                 err_event;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 send_cgs, send_ilas, data_en, lmfc_bnd;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A K reduced below the current count must wrap on the next tick, hence >=.
    assign boundary  = lnk.frame_clk && (frame_cnt >= k_q);
    assign err_event = lnk.i_err_reporting && !err_prev &&
                       (state == ST_ILAS || state == ST_DATA);

    always_comb begin
        state_nxt    = state;
        ilas_idx_nxt = ilas_idx;
        case (state)
            ST_CGS: begin
                ilas_idx_nxt = 3'd0;
                if (lnk.i_sync_de_assertion && !lnk.i_sync_request_tx)
                    state_nxt = ST_WAIT_LMFC;
            end
            ST_WAIT_LMFC: begin
                if (lnk.i_sync_request_tx || !lnk.i_sync_de_assertion) begin
                    state_nxt = ST_CGS;
                end else if (boundary) begin
                    state_nxt    = ST_ILAS;
                    ilas_idx_nxt = 3'd0;
                end
            end
            ST_ILAS: begin
                if (lnk.i_sync_request_tx) begin
                    state_nxt    = ST_CGS;
                    ilas_idx_nxt = 3'd0;
                end else if (boundary) begin
                    if (ilas_idx == ILAS_LAST) begin
                        state_nxt    = ST_DATA;
                        ilas_idx_nxt = 3'd0;
                    end else begin
                        ilas_idx_nxt = ilas_idx + 3'd1;
                    end
                end
            end
            ST_DATA: begin
                ilas_idx_nxt = 3'd0;
                if (lnk.i_sync_request_tx)
                    state_nxt = ST_CGS;
            end
            default: begin
                state_nxt    = ST_CGS;
                ilas_idx_nxt = 3'd0;
            end
        endcase
    end

    // Mode outputs are decoded from the next state so they switch with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CGS;
            ilas_idx  <= 3'd0;
            send_cgs  <= 1'b1;
            send_ilas <= 1'b0;
            data_en   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ilas_idx  <= ilas_idx_nxt;
            send_cgs  <= (state_nxt == ST_CGS) || (state_nxt == ST_WAIT_LMFC);
            send_ilas <= (state_nxt == ST_ILAS);
            data_en   <= (state_nxt == ST_DATA);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q       <= 5'd0;
            frame_cnt <= 5'd0;
            lmfc_bnd  <= 1'b0;
        end else begin
            if (state == ST_CGS)
                k_q <= lnk.i_K;
            if (lnk.frame_clk)
                frame_cnt <= (frame_cnt >= k_q) ? 5'd0 : frame_cnt + 5'd1;
            lmfc_bnd <= boundary;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_prev <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err_prev <= lnk.i_err_reporting;
            if (err_event)
                err_cnt <= sat_inc(err_cnt);
        end
    end

    assign lnk.o_state         = state;
    assign lnk.o_send_cgs      = send_cgs;
    assign lnk.o_send_ilas     = send_ilas;
    assign lnk.o_data_en       = data_en;
    assign lnk.o_ilas_mf_idx   = ilas_idx;
    assign lnk.o_frame_in_mf   = frame_cnt;
    assign lnk.o_lmfc_boundary = lmfc_bnd;
    assign lnk.o_err_cnt       = err_cnt;

endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Directed bench for jesd_tx_link_ctrl: LMFC counting, CGS/ILAS/DATA sequencing,
// error counter saturation, sync-request priority and asynchronous reset.
module tb_jesd_tx_link_ctrl;

    localparam int ILAS_MF   = 4;
    localparam int ERR_CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   fc_en = 1'b0;
    bit   last_tick;
    int   exp_cnt = 0;
    int   exp_k = 0;
    int   exp_bnd = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   edge_no = 0;

    jesd_tx_link_ctrl_if #(.ERR_CNT_W(ERR_CNT_W)) bif ();

    jesd_tx_link_ctrl #(.ILAS_MF(ILAS_MF), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lnk   (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clk edge: LMFC reference model, per-cycle checks, then frame tick for the next edge.
    task automatic step();
        bit tick;
        tick = bif.frame_clk;
        @(posedge clk);
        edge_no++;
        last_tick = tick;
        if (tick) begin
            exp_bnd = (exp_cnt >= exp_k) ? 1 : 0;
            exp_cnt = (exp_cnt >= exp_k) ? 0 : exp_cnt + 1;
        end else begin
            exp_bnd = 0;
        end
        exp_k = int'(bif.i_K);
        #1;
        check("lmfc_cnt", 32'(bif.o_frame_in_mf), 32'(exp_cnt));
        check("lmfc_bnd", 32'(bif.o_lmfc_boundary), 32'(exp_bnd));
        check("mode_onehot", 32'(bif.o_send_cgs) + 32'(bif.o_send_ilas) + 32'(bif.o_data_en), 32'd1);
        bif.frame_clk = fc_en ? ~bif.frame_clk : 1'b0;
    endtask

    task automatic err_pulse();
        bif.i_err_reporting = 1'b1;
        step();
        step();
        bif.i_err_reporting = 1'b0;
        step();
    endtask

    initial begin
        int  n_bnd, first_bnd, last_bnd, n_ticks;
        bit  found;

        bif.frame_clk           = 1'b0;
        bif.i_K                 = 5'd3;
        bif.i_sync_request_tx   = 1'b0;
        bif.i_err_reporting     = 1'b0;
        bif.i_sync_de_assertion = 1'b0;

        // Reset values while rst_n is held low
        #12;
        check("rst_state", 32'(bif.o_state), 32'd0);
        check("rst_cgs", 32'(bif.o_send_cgs), 32'd1);
        check("rst_ilas", 32'(bif.o_send_ilas), 32'd0);
        check("rst_data", 32'(bif.o_data_en), 32'd0);
        check("rst_idx", 32'(bif.o_ilas_mf_idx), 32'd0);
        check("rst_fim", 32'(bif.o_frame_in_mf), 32'd0);
        check("rst_err", 32'(bif.o_err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fc_en = 1'b1;

        // Idle CGS: counter cycles 0..3, boundary every 8 clk
        n_bnd = 0; first_bnd = 0; last_bnd = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("cgs_state", 32'(bif.o_state), 32'd0);
            check("cgs_send", 32'(bif.o_send_cgs), 32'd1);
            if (bif.o_lmfc_boundary) begin
                if (n_bnd == 0) first_bnd = edge_no;
                last_bnd = edge_no;
                n_bnd++;
            end
        end
        check("bnd_count", 32'(n_bnd), 32'd2);
        check("bnd_period", 32'(last_bnd - first_bnd), 32'd8);

        // De-assertion at count 1 -> WAIT_LMFC -> ILAS on count-3 tick
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bif.o_frame_in_mf == 5'd1 && bif.frame_clk == 1'b0) found = 1'b1;
        end
        check("seek_fim1", 32'(found), 32'd1);
        bif.i_sync_de_assertion = 1'b1;
        step();
        check("wait_state", 32'(bif.o_state), 32'd1);
        check("wait_cgs", 32'(bif.o_send_cgs), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (bif.o_state != 2'd1) found = 1'b1;
        end
        check("ilas_state", 32'(bif.o_state), 32'd2);
        check("ilas_send", 32'(bif.o_send_ilas), 32'd1);
        check("ilas_fim0", 32'(bif.o_frame_in_mf), 32'd0);
        check("ilas_entry_bnd", 32'(bif.o_lmfc_boundary), 32'd1);
        check("ilas_idx0", 32'(bif.o_ilas_mf_idx), 32'd0);

        // ILAS lasts 16 ticks, index steps 0..3
        n_ticks = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (last_tick) n_ticks++;
            if (n_ticks < 16) begin
                check("ilas_hold", 32'(bif.o_state), 32'd2);
                check("ilas_idx", 32'(bif.o_ilas_mf_idx), 32'(n_ticks / 4));
            end else begin
                found = 1'b1;
            end
        end
        check("ilas_len_done", 32'(found), 32'd1);
        check("data_state", 32'(bif.o_state), 32'd3);
        check("data_en", 32'(bif.o_data_en), 32'd1);
        check("data_idx", 32'(bif.o_ilas_mf_idx), 32'd0);

        // Error reporting in DATA: count, no state change, saturation
        for (int i = 0; i < 3; i++) err_pulse();
        check("err_state", 32'(bif.o_state), 32'd3);
        check("err_cnt3", 32'(bif.o_err_cnt), 32'd3);
        for (int i = 0; i < 252; i++) err_pulse();
        check("err_cnt255", 32'(bif.o_err_cnt), 32'd255);
        for (int i = 0; i < 45; i++) err_pulse();
        check("err_sat", 32'(bif.o_err_cnt), 32'd255);
        check("err_state2", 32'(bif.o_state), 32'd3);

        // Sync request in DATA -> CGS, then back into ILAS
        bif.i_sync_request_tx = 1'b1;
        step();
        check("data_req_state", 32'(bif.o_state), 32'd0);
        check("data_req_cgs", 32'(bif.o_send_cgs), 32'd1);
        bif.i_sync_request_tx = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (bif.o_state == 2'd2 && bif.o_ilas_mf_idx == 3'd2) found = 1'b1;
        end
        check("seek_idx2", 32'(found), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bif.frame_clk && exp_cnt >= exp_k) found = 1'b1;
            else step();
        end
        check("seek_bnd", 32'(found), 32'd1);
        check("pre_req_idx", 32'(bif.o_ilas_mf_idx), 32'd2);
        bif.i_sync_request_tx = 1'b1;
        step();
        check("req_bnd_state", 32'(bif.o_state), 32'd0);
        check("req_bnd_idx", 32'(bif.o_ilas_mf_idx), 32'd0);
        check("req_bnd_cgs", 32'(bif.o_send_cgs), 32'd1);
        check("req_bnd_ilas", 32'(bif.o_send_ilas), 32'd0);

        // WAIT_LMFC abandoned when de-assertion drops before a boundary
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (exp_cnt == 0 && bif.frame_clk == 1'b0) found = 1'b1;
        end
        check("seek_cnt0", 32'(found), 32'd1);
        bif.i_sync_request_tx = 1'b0;
        step();
        check("wait2_state", 32'(bif.o_state), 32'd1);
        bif.i_sync_de_assertion = 1'b0;
        step();
        check("wait_abort_state", 32'(bif.o_state), 32'd0);
        check("wait_abort_idx", 32'(bif.o_ilas_mf_idx), 32'd0);

        // K lowered below the current count in CGS wraps on the next tick
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (exp_cnt == 2 && bif.frame_clk == 1'b0) found = 1'b1;
        end
        check("seek_cnt2", 32'(found), 32'd1);
        bif.i_K = 5'd1;
        step();
        step();
        check("kdec_fim", 32'(bif.o_frame_in_mf), 32'd0);
        check("kdec_bnd", 32'(bif.o_lmfc_boundary), 32'd1);
        step();
        step();
        check("k1_fim", 32'(bif.o_frame_in_mf), 32'd1);
        bif.i_K = 5'd3;
        step();

        // Asynchronous reset mid-DATA
        bif.i_sync_de_assertion = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (bif.o_state == 2'd3) found = 1'b1;
        end
        check("reach_data", 32'(found), 32'd1);
        check("err_kept", 32'(bif.o_err_cnt), 32'd255);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(bif.o_state), 32'd0);
        check("arst_cgs", 32'(bif.o_send_cgs), 32'd1);
        check("arst_data", 32'(bif.o_data_en), 32'd0);
        check("arst_fim", 32'(bif.o_frame_in_mf), 32'd0);
        check("arst_err", 32'(bif.o_err_cnt), 32'd0);
        bif.i_sync_de_assertion = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_k = 0;
        bif.frame_clk = 1'b0;
        step();
        check("post_rst_state", 32'(bif.o_state), 32'd0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jesd_tx_link_ctrl.md
Name: jesd_tx_link_ctrl

Overview:
Transmit-side JESD204B link-layer sequencer. Consumes the decoded SYNC~ events and drives the TX datapath through code group synchronisation (CGS), initial lane alignment sequence (ILAS) and user data phases. Keeps a free-running LMFC (frame-in-multiframe) counter so that the CGS-to-ILAS switch lands on a multiframe boundary. Counts error-reporting events for debug.

Parameters:
ILAS_MF, 4, number of multiframes in ILAS (legal 1..8)
ERR_CNT_W, 8, width of saturating error-report counter

Ports:
clk  input  1  device clock (2x frame rate)
rst_n  input  1  asynchronous active-low reset
frame_clk  input  1  one-clk-cycle strobe marking each frame boundary (frame tick)
i_K  input  5  frames per multiframe minus 1 (0..31)
i_sync_request_tx  input  1  link re-init request (level; SYNC~ low for 4+ frames)
i_err_reporting  input  1  SYNC~ high-to-low seen (level, clears when SYNC~ high)
i_sync_de_assertion  input  1  SYNC~ low-to-high seen (level, clears when SYNC~ low)
o_state  output  2  0=CGS, 1=WAIT_LMFC, 2=ILAS, 3=DATA
o_send_cgs  output  1  datapath emits K28.5
o_send_ilas  output  1  datapath emits ILAS
o_data_en  output  1  datapath emits user data
o_ilas_mf_idx  output  3  current ILAS multiframe index
o_frame_in_mf  output  5  current LMFC frame position
o_lmfc_boundary  output  1  one-cycle pulse: frame tick that ends a multiframe
o_err_cnt  output  ERR_CNT_W  saturating count of error-report events

Behaviour:
- Async reset (rst_n low): state CGS, o_send_cgs=1, o_send_ilas=0, o_data_en=0, o_ilas_mf_idx=0, o_frame_in_mf=0, o_lmfc_boundary=0, o_err_cnt=0, latched K_q=0.
- All outputs registered; mode outputs change on the same clk edge as the state register. Exactly one of o_send_cgs/o_send_ilas/o_data_en is high; WAIT_LMFC asserts o_send_cgs.
- K latch: K_q <= i_K on every clk while state==CGS; frozen in all other states.
- LMFC counter (o_frame_in_mf): free-running from reset in all states; on frame_clk, if count >= K_q then 0 else count+1. Using >= means a K decrease below the current count wraps on the next tick. No change without frame_clk.
- boundary = frame_clk && count >= K_q (combinational); o_lmfc_boundary is boundary registered (1-cycle delay, 1-cycle width).
- FSM (priority top-down within each state):
  CGS: i_sync_de_assertion=1 and i_sync_request_tx=0 -> WAIT_LMFC.
  WAIT_LMFC: i_sync_request_tx=1 or i_sync_de_assertion=0 -> CGS; else boundary -> ILAS with ilas_mf_idx=0.
  ILAS: i_sync_request_tx=1 -> CGS; else on boundary: if ilas_mf_idx==ILAS_MF-1 -> DATA, else ilas_mf_idx+1.
  DATA: i_sync_request_tx=1 -> CGS; otherwise stay.
- Frame 0 of the first ILAS multiframe is the frame starting after the boundary tick, so ILAS spans exactly ILAS_MF*(K_q+1) frame ticks.
- o_ilas_mf_idx: 0 outside ILAS; reset to 0 on every CGS entry.
- Error counter: rising edge of i_err_reporting (registered previous value) while state==DATA or ILAS increments o_err_cnt; saturates at all-ones. Cleared only by rst_n. Error reporting alone never changes state; only i_sync_request_tx does.
- A simultaneous boundary and i_sync_request_tx always resolves to CGS.
- rst_n asserted mid-ILAS/DATA returns to reset values immediately (async). Exit is synchronous on the next clk.

Test Plan:
- Reset, K=3, frame_clk every 2nd clk, SYNC events idle -> o_state=0, o_send_cgs=1, o_frame_in_mf cycles 0,1,2,3,0; o_lmfc_boundary pulses once every 8 clk.
- From CGS, raise i_sync_de_assertion at o_frame_in_mf=1 -> WAIT_LMFC. ILAS entered on tick where count=3. DATA entered after 16 further ticks (ILAS_MF=4), with o_ilas_mf_idx stepping 0..3.
- In DATA, pulse i_err_reporting 3 times (no sync request) -> state stays DATA, o_err_cnt=3. With ERR_CNT_W=8 and 300 pulses -> o_err_cnt=255.
- In ILAS idx=2, assert i_sync_request_tx coincident with a boundary -> next state CGS, o_ilas_mf_idx=0, o_send_cgs=1.
- In WAIT_LMFC, drop i_sync_de_assertion before boundary -> return CGS; change i_K 3->1 while count=3 in CGS -> next tick count=0.
- Assert rst_n low mid-DATA between clk edges -> outputs reset values without waiting for clk; o_err_cnt=0.
